// File: rtl/internal_framebuffer_loader.sv
// Internal framebuffer loader: accepts an AXI-Stream of pixel beats and writes
// them to consecutive framebuffer RAM words. It flags a sticky error when the
// stream length does not match the commanded size.
module internal_framebuffer_loader #(
  parameter int NUMBER_OF_PIXELS_PER_BEAT    = 1,
  parameter int NUMBER_OF_SUB_PIXELS         = 4,
  parameter int SUB_PIXEL_WIDTH              = 8,
  parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
  parameter int FB_SIZE_IN_PIXEL_LG          = 20,
  localparam int PIXEL_LG       = $clog2(NUMBER_OF_PIXELS_PER_BEAT),
  localparam int STREAM_WIDTH   = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
  localparam int MASK_WIDTH     = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS,
  localparam int MEM_ADDR_WIDTH = FRAMEBUFFER_SIZE_IN_PIXEL_LG - PIXEL_LG
) (
  input  logic                            aclk,
  input  logic                            resetn,

  input  logic [NUMBER_OF_SUB_PIXELS-1:0] confMask,

  input  logic                            apply,
  output logic                            applied,
  input  logic                            cmdLoad,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0]  cmdSize,

  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0]         s_axis_tdata,

  output logic [STREAM_WIDTH-1:0]         writeDataPort,
  output logic                            writeEnablePort,
  output logic [MEM_ADDR_WIDTH-1:0]       writeAddrPort,
  output logic [MASK_WIDTH-1:0]           writeMaskPort,

  output logic                            loadError
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  state_t                            state;
  state_t                            state_next;

  logic [FB_SIZE_IN_PIXEL_LG-1:0]    beats_total;
  logic [FB_SIZE_IN_PIXEL_LG-1:0]    beats_done;
  logic [FB_SIZE_IN_PIXEL_LG-1:0]    beats_done_inc;
  logic [NUMBER_OF_SUB_PIXELS-1:0]   conf_mask_q;
  logic [MEM_ADDR_WIDTH-1:0]         addr;

  logic                              start;
  logic                              store_beat;
  logic                              error_set;

  assign beats_done_inc = beats_done + FB_SIZE_IN_PIXEL_LG'(1);

  // State register.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, handshake and command decode.
  // applied is held low while the final beat's write is still on the port, so
  // "applied" only rises once every write of the command has been presented;
  // new commands are likewise refused during that cycle.
  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    applied       = 1'b0;
    start         = 1'b0;
    store_beat    = 1'b0;
    error_set     = 1'b0;
    case (state)
      IDLE: begin
        applied = !writeEnablePort;
        if (apply && cmdLoad && !writeEnablePort) begin
          start      = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        s_axis_tready = (beats_done < beats_total);
        if (beats_total == '0) begin
          state_next = IDLE;
        end else if (s_axis_tvalid && s_axis_tready) begin
          store_beat = 1'b1;
          if (beats_done_inc == beats_total) begin
            if (s_axis_tlast) begin
              state_next = IDLE;
            end else begin
              error_set  = 1'b1;
              state_next = DRAIN;
            end
          end else if (s_axis_tlast) begin
            error_set  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command latch, beat/address counters, registered write port and error flag.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      beats_total     <= '0;
      beats_done      <= '0;
      conf_mask_q     <= '0;
      addr            <= '0;
      loadError       <= 1'b0;
      writeEnablePort <= 1'b0;
      writeDataPort   <= '0;
      writeAddrPort   <= '0;
      writeMaskPort   <= '0;
    end else begin
      writeEnablePort <= store_beat;
      if (start) begin
        beats_total <= cmdSize >> PIXEL_LG;
        beats_done  <= '0;
        conf_mask_q <= confMask;
        addr        <= '0;
        loadError   <= 1'b0;
      end
      if (store_beat) begin
        writeDataPort <= s_axis_tdata;
        writeAddrPort <= addr;
        writeMaskPort <= {NUMBER_OF_PIXELS_PER_BEAT{conf_mask_q}};
        addr          <= addr + MEM_ADDR_WIDTH'(1);
        beats_done    <= beats_done_inc;
      end
      if (error_set) begin
        loadError <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_internal_framebuffer_loader.sv
// Self-checking bench for internal_framebuffer_loader (1 pixel/beat, 4x8 bits,
// 16-word memory so that address wrap is reachable).
module tb_internal_framebuffer_loader;

  localparam int PPB  = 1;
  localparam int NSUB = 4;
  localparam int SPW  = 8;
  localparam int FBLG = 4;
  localparam int SZLG = 20;
  localparam int SW   = PPB * NSUB * SPW;
  localparam int MW   = PPB * NSUB;
  localparam int AW   = FBLG;

  logic            aclk = 1'b0;
  logic            resetn = 1'b0;
  logic [NSUB-1:0] confMask = '0;
  logic            apply = 1'b0;
  logic            applied;
  logic            cmdLoad = 1'b0;
  logic [SZLG-1:0] cmdSize = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic            s_axis_tlast = 1'b0;
  logic [SW-1:0]   s_axis_tdata = '0;
  logic [SW-1:0]   writeDataPort;
  logic            writeEnablePort;
  logic [AW-1:0]   writeAddrPort;
  logic [MW-1:0]   writeMaskPort;
  logic            loadError;

  always #5 aclk = ~aclk;

  internal_framebuffer_loader #(
    .NUMBER_OF_PIXELS_PER_BEAT(PPB),
    .NUMBER_OF_SUB_PIXELS(NSUB),
    .SUB_PIXEL_WIDTH(SPW),
    .FRAMEBUFFER_SIZE_IN_PIXEL_LG(FBLG),
    .FB_SIZE_IN_PIXEL_LG(SZLG)
  ) dut (
    .aclk(aclk),
    .resetn(resetn),
    .confMask(confMask),
    .apply(apply),
    .applied(applied),
    .cmdLoad(cmdLoad),
    .cmdSize(cmdSize),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata),
    .writeDataPort(writeDataPort),
    .writeEnablePort(writeEnablePort),
    .writeAddrPort(writeAddrPort),
    .writeMaskPort(writeMaskPort),
    .loadError(loadError)
  );

  int total = 0;
  int bad   = 0;

  // observed RAM writes
  logic [AW-1:0] obs_addr[$];
  logic [SW-1:0] obs_data[$];
  logic [MW-1:0] obs_mask[$];

  always @(negedge aclk) begin
    if (writeEnablePort === 1'b1) begin
      obs_addr.push_back(writeAddrPort);
      obs_data.push_back(writeDataPort);
      obs_mask.push_back(writeMaskPort);
    end
  end

  // stimulus stream and expected results
  logic [SW-1:0] beat_data[$];
  bit            beat_last[$];
  logic [AW-1:0] exp_addr[$];
  logic [SW-1:0] exp_data[$];
  logic [MW-1:0] exp_mask[$];
  bit            exp_err;

  // Reference: beat i of the stream is written to address i mod memory size
  // while i < N; the command ends at the first tlast; the error flag is set
  // unless that tlast sits exactly on beat N.
  task automatic model(input int n, input logic [NSUB-1:0] m);
    exp_addr.delete(); exp_data.delete(); exp_mask.delete();
    exp_err = 1'b0;
    if (n == 0) return;
    for (int i = 0; i < beat_data.size(); i++) begin
      if (i < n) begin
        exp_addr.push_back(AW'(i % (1 << AW)));
        exp_data.push_back(beat_data[i]);
        exp_mask.push_back({PPB{m}});
      end
      if (beat_last[i]) begin
        exp_err = (i + 1 != n);
        return;
      end
      if (i == n - 1) exp_err = 1'b1;
    end
  endtask

  task automatic build_stream(input int last_idx);
    beat_data.delete(); beat_last.delete();
    for (int i = 0; i <= last_idx; i++) begin
      beat_data.push_back(SW'($urandom));
      beat_last.push_back(i == last_idx);
    end
  endtask

  // Presents one beat at a negedge and returns at the negedge after acceptance.
  task automatic drive_beat(input logic [SW-1:0] d, input bit l, output bit ok);
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int c = 0; c < 40; c++) begin
      if (s_axis_tready === 1'b1) begin
        @(negedge aclk);
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
  endtask

  // Issues a load and streams beat_data. gaps<0: random 0..2 idle cycles per
  // beat. noise: wiggle apply while the command is running.
  task automatic do_load(input int size, input logic [NSUB-1:0] m, input int gaps,
                         input bit noise, output bit last_we, output bit last_applied);
    bit ok;
    int g;
    obs_addr.delete(); obs_data.delete(); obs_mask.delete();
    last_we = 1'b0; last_applied = 1'b1;
    apply = 1'b1; cmdLoad = 1'b1; cmdSize = SZLG'(size); confMask = m;
    @(negedge aclk);
    apply = 1'b0; cmdLoad = 1'b0;
    if (size > 0) begin
      foreach (beat_data[i]) begin
        g = (gaps < 0) ? int'($urandom_range(0, 2)) : gaps;
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < g; k++) begin
          if (noise) begin
            apply = 1'b1; cmdLoad = 1'b1; cmdSize = SZLG'(1);
          end
          @(negedge aclk);
        end
        apply = 1'b0; cmdLoad = 1'b0;
        drive_beat(beat_data[i], beat_last[i], ok);
        if (!ok) begin
          total++; bad++;
          $display("FAIL beat_accept_timeout beat=%0d got=no_tready want=tready", i);
          s_axis_tvalid = 1'b0;
          return;
        end
      end
      last_we = writeEnablePort;
      last_applied = applied;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (applied === 1'b1) break;
      @(negedge aclk);
    end
    if (applied !== 1'b1) begin
      total++; bad++;
      $display("FAIL idle_timeout got applied=%b want=1", applied);
    end
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge aclk);
    total++;
    if ({applied, s_axis_tready, writeEnablePort, loadError} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctrl got applied/tready/we/err=%b%b%b%b want=1000",
               applied, s_axis_tready, writeEnablePort, loadError);
    end
    total++;
    if ({writeDataPort, writeAddrPort, writeMaskPort} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h want=0/0/0", writeDataPort, writeAddrPort, writeMaskPort);
    end
    resetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_basic();
    bit lwe, lap;
    beat_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    beat_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    model(4, 4'hF);
    do_load(4, 4'hF, 0, 1'b0, lwe, lap);
    total++;
    if (obs_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL basic_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end else foreach (exp_addr[i]) begin
      total++;
      if ({obs_addr[i], obs_data[i], obs_mask[i]} !== {exp_addr[i], exp_data[i], exp_mask[i]}) begin
        bad++; $display("FAIL basic_write%0d got=%h/%h/%h want=%h/%h/%h", i,
                        obs_addr[i], obs_data[i], obs_mask[i], exp_addr[i], exp_data[i], exp_mask[i]);
      end
    end
    total++;
    if (loadError !== exp_err) begin
      bad++; $display("FAIL basic_err got=%b want=%b", loadError, exp_err);
    end
    total++;
    if ({lwe, lap} !== 2'b10) begin
      bad++; $display("FAIL basic_last_write_applied got we/applied=%b%b want=10", lwe, lap);
    end
  endtask

  task automatic test_stall();
    bit lwe, lap;
    beat_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    beat_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    model(4, 4'hF);
    do_load(4, 4'hF, 1, 1'b1, lwe, lap);
    total++;
    if (obs_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL stall_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end else foreach (exp_addr[i]) begin
      total++;
      if ({obs_addr[i], obs_data[i], obs_mask[i]} !== {exp_addr[i], exp_data[i], exp_mask[i]}) begin
        bad++; $display("FAIL stall_write%0d got=%h/%h/%h want=%h/%h/%h", i,
                        obs_addr[i], obs_data[i], obs_mask[i], exp_addr[i], exp_data[i], exp_mask[i]);
      end
    end
    total++;
    if (loadError !== 1'b0) begin
      bad++; $display("FAIL stall_err got=%b want=0", loadError);
    end
  endtask

  task automatic test_length_errors();
    bit lwe, lap;
    // longer stream than commanded: extra beat drained
    build_stream(2);
    model(2, 4'hF);
    do_load(2, 4'hF, 0, 1'b0, lwe, lap);
    total++;
    if (obs_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL long_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end else foreach (exp_addr[i]) begin
      total++;
      if ({obs_addr[i], obs_data[i]} !== {exp_addr[i], exp_data[i]}) begin
        bad++; $display("FAIL long_write%0d got=%h/%h want=%h/%h", i,
                        obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    total++;
    if ({loadError, s_axis_tready} !== {exp_err, 1'b0}) begin
      bad++; $display("FAIL long_err_tready got=%b%b want=%b0", loadError, s_axis_tready, exp_err);
    end
    // shorter stream than commanded
    build_stream(1);
    model(4, 4'hF);
    do_load(4, 4'hF, 0, 1'b0, lwe, lap);
    total++;
    if (obs_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL short_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end else foreach (exp_addr[i]) begin
      total++;
      if ({obs_addr[i], obs_data[i]} !== {exp_addr[i], exp_data[i]}) begin
        bad++; $display("FAIL short_write%0d got=%h/%h want=%h/%h", i,
                        obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    total++;
    if ({loadError, applied} !== {exp_err, 1'b1}) begin
      bad++; $display("FAIL short_err_applied got=%b%b want=%b1", loadError, applied, exp_err);
    end
  endtask

  task automatic test_mask_zero();
    bit lwe, lap;
    bit a1, a2;
    build_stream(0);
    model(1, 4'b0101);
    do_load(1, 4'b0101, 0, 1'b0, lwe, lap);
    total++;
    if (obs_mask.size() != 1 || obs_mask[0] !== 4'b0101 || obs_addr[0] !== '0) begin
      bad++; $display("FAIL mask_write got count=%0d mask=%b want count=1 mask=0101",
                      obs_mask.size(), (obs_mask.size() > 0) ? obs_mask[0] : 4'hx);
    end
    // cmdLoad=0 is not a command
    apply = 1'b1; cmdLoad = 1'b0; cmdSize = SZLG'(3);
    @(negedge aclk);
    a1 = applied;
    apply = 1'b0;
    @(negedge aclk);
    total++;
    if ({a1, applied, s_axis_tready} !== 3'b110) begin
      bad++; $display("FAIL noload_ignored got applied/applied/tready=%b%b%b want=110",
                      a1, applied, s_axis_tready);
    end
    // zero-size load: one busy cycle, no writes, no beats taken
    obs_addr.delete(); obs_data.delete(); obs_mask.delete();
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tdata = SW'(32'hDEAD);
    apply = 1'b1; cmdLoad = 1'b1; cmdSize = '0; confMask = 4'hF;
    @(negedge aclk);
    apply = 1'b0; cmdLoad = 1'b0;
    a1 = applied;
    total++;
    if ({a1, s_axis_tready} !== 2'b00) begin
      bad++; $display("FAIL zero_busy got applied/tready=%b%b want=00", a1, s_axis_tready);
    end
    @(negedge aclk);
    a2 = applied;
    repeat (3) @(negedge aclk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    total++;
    if (a2 !== 1'b1 || obs_addr.size() != 0 || applied !== 1'b1) begin
      bad++; $display("FAIL zero_done got applied=%b writes=%0d want applied=1 writes=0",
                      a2, obs_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, lwe, lap;
    obs_addr.delete(); obs_data.delete(); obs_mask.delete();
    build_stream(3);
    apply = 1'b1; cmdLoad = 1'b1; cmdSize = SZLG'(4); confMask = 4'hF;
    @(negedge aclk);
    apply = 1'b0; cmdLoad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_beat(beat_data[i], 1'b0, ok);
      if (!ok) begin
        total++; bad++; $display("FAIL midreset_accept_timeout got=no_tready want=tready");
      end
    end
    s_axis_tdata = beat_data[2];
    resetn = 1'b0;
    @(negedge aclk);
    total++;
    if ({applied, s_axis_tready, writeEnablePort, loadError} !== 4'b1000 ||
        {writeDataPort, writeAddrPort, writeMaskPort} !== '0) begin
      bad++; $display("FAIL midreset_state got applied/tready/we/err=%b%b%b%b data=%h want=1000 data=0",
                      applied, s_axis_tready, writeEnablePort, loadError, writeDataPort);
    end
    resetn = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    total++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 4'd0 || obs_addr[1] !== 4'd1) begin
      bad++; $display("FAIL midreset_writes got count=%0d want=2 (addr 0,1)", obs_addr.size());
    end
    build_stream(0);
    model(1, 4'h3);
    do_load(1, 4'h3, 0, 1'b0, lwe, lap);
    total++;
    if (obs_addr.size() != 1 || {obs_addr[0], obs_data[0], obs_mask[0]} !== {exp_addr[0], exp_data[0], exp_mask[0]}) begin
      bad++; $display("FAIL midreset_reload got count=%0d want=1 at addr 0", obs_addr.size());
    end
  endtask

  task automatic test_wrap();
    bit lwe, lap;
    build_stream(19);
    model(20, 4'hA);
    do_load(20, 4'hA, 0, 1'b0, lwe, lap);
    total++;
    if (obs_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL wrap_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
    end else foreach (exp_addr[i]) begin
      total++;
      if ({obs_addr[i], obs_data[i], obs_mask[i]} !== {exp_addr[i], exp_data[i], exp_mask[i]}) begin
        bad++; $display("FAIL wrap_write%0d got=%h/%h/%h want=%h/%h/%h", i,
                        obs_addr[i], obs_data[i], obs_mask[i], exp_addr[i], exp_data[i], exp_mask[i]);
      end
    end
    total++;
    if (loadError !== exp_err) begin
      bad++; $display("FAIL wrap_err got=%b want=%b", loadError, exp_err);
    end
  endtask

  task automatic test_random();
    bit lwe, lap;
    int size;
    logic [NSUB-1:0] m;
    for (int it = 0; it < 30; it++) begin
      size = int'($urandom_range(0, 6));
      m = NSUB'($urandom);
      if (size > 0) build_stream(int'($urandom_range(0, size + 2)));
      else begin
        beat_data.delete(); beat_last.delete();
      end
      model(size, m);
      do_load(size, m, -1, 1'b0, lwe, lap);
      total++;
      if (obs_addr.size() != exp_addr.size()) begin
        bad++; $display("FAIL rand%0d_count got=%0d want=%0d", it, obs_addr.size(), exp_addr.size());
      end else foreach (exp_addr[i]) begin
        total++;
        if ({obs_addr[i], obs_data[i], obs_mask[i]} !== {exp_addr[i], exp_data[i], exp_mask[i]}) begin
          bad++; $display("FAIL rand%0d_write%0d got=%h/%h/%h want=%h/%h/%h", it, i,
                          obs_addr[i], obs_data[i], obs_mask[i], exp_addr[i], exp_data[i], exp_mask[i]);
        end
      end
      total++;
      if (loadError !== exp_err) begin
        bad++; $display("FAIL rand%0d_err got=%b want=%b", it, loadError, exp_err);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge aclk);
    test_reset();
    test_basic();
    test_stall();
    test_length_errors();
    test_mask_zero();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
